// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : cache_controller
//  Purpose  : 2-way set-associative, write-through, no-write-allocate data
//             cache between the MEM stage and the SRAM controller. Read hits
//             complete in the request cycle; misses and all writes are
//             forwarded over the SRAM controller's enable/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_controller #(
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned INDEX_W   = 6,
    parameter int unsigned TAG_W     = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int unsigned SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_MISS = 2'd1,
        S_WR      = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Per-set metadata: valid bits and LRU bit (value = way to evict next)
    logic [SETS-1:0]  valid0_q, valid1_q;
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_q  [2][SETS];
    logic [31:0]      data_q [2][SETS];

    logic [31:0]        w_off;
    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit0, w_hit1, w_hit, w_hit_way;
    logic               w_victim;
    logic               w_rd_en, w_wr_en;
    logic               w_fill, w_wr_hit, w_rd_hit;
    logic               w_unused_bits;

    // Address is rebased to the data-memory origin before splitting
    assign w_off         = address - 32'(BASE_ADDR);
    assign w_index       = w_off[INDEX_W+1:2];
    assign w_tag         = w_off[INDEX_W+TAG_W+1:INDEX_W+2];
    assign w_unused_bits = ^{w_off[31:INDEX_W+TAG_W+2], w_off[1:0]};

    assign w_hit0    = valid0_q[w_index] && (tag_q[0][w_index] == w_tag);
    assign w_hit1    = valid1_q[w_index] && (tag_q[1][w_index] == w_tag);
    assign w_hit     = w_hit0 | w_hit1;
    assign w_hit_way = ~w_hit0;

    // Invalid way first (way0 preferred), otherwise the LRU way
    assign w_victim = !valid0_q[w_index] ? 1'b0 :
                      !valid1_q[w_index] ? 1'b1 : lru_q[w_index];

    // Array update strobes, each taking effect at the next clock edge
    assign w_fill   = (state_q == S_RD_MISS) && sram_ready;
    assign w_wr_hit = (state_q == S_WR) && sram_ready && w_hit;
    assign w_rd_hit = (state_q == S_IDLE) && MEM_R_EN && !MEM_W_EN && w_hit;

    // Enables are forced low while reset is held so an interrupted op stops at once
    assign sram_rd_en   = w_rd_en & ~rst;
    assign sram_wr_en   = w_wr_en & ~rst;
    assign sram_address = address;
    assign sram_wdata   = wdata;

    // Next-state and handshake outputs
    always_comb begin
        state_d = state_q;
        ready   = 1'b1;
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        rdata   = w_hit1 ? data_q[1][w_index] : data_q[0][w_index];
        case (state_q)
            S_IDLE: begin
                if (MEM_W_EN) begin
                    ready   = 1'b0;
                    w_wr_en = 1'b1;
                    state_d = S_WR;
                end else if (MEM_R_EN && !w_hit) begin
                    ready   = 1'b0;
                    w_rd_en = 1'b1;
                    state_d = S_RD_MISS;
                end
            end
            S_RD_MISS: begin
                w_rd_en = 1'b1;
                rdata   = sram_rdata;
                ready   = sram_ready;
                if (sram_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                w_wr_en = 1'b1;
                ready   = sram_ready;
                if (sram_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register, valid bits and LRU bits (all cleared by reset)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            state_q <= state_d;
            if (w_fill) begin
                if (w_victim) begin
                    valid1_q[w_index] <= 1'b1;
                end else begin
                    valid0_q[w_index] <= 1'b1;
                end
                lru_q[w_index] <= ~w_victim;
            end else if (w_rd_hit || w_wr_hit) begin
                lru_q[w_index] <= ~w_hit_way;
            end
        end
    end

    // Tag and data arrays: filled on read-miss return, updated on write hit
    always_ff @(posedge clk) begin
        if (w_fill) begin
            tag_q[w_victim][w_index]  <= w_tag;
            data_q[w_victim][w_index] <= sram_rdata;
        end else if (w_wr_hit) begin
            data_q[w_hit_way][w_index] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_controller
//  Purpose  : Self-checking bench for cache_controller: vector table of
//             accesses with a bench-side SRAM responder and an rdata
//             scoreboard, plus hand-written reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] address, wdata, rdata;
    logic        ready;
    logic        sram_rd_en, sram_wr_en;
    logic [31:0] sram_address, sram_wdata, sram_rdata;
    logic        sram_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] sdata;
        bit          exp_sram;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .sram_rd_en   (sram_rd_en),
        .sram_wr_en   (sram_wr_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got rdata %h with empty scoreboard, expected an entry", name, rdata);
        end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (rdata !== e) begin
                n_fail++;
                $display("FAIL %s: got rdata %h expected %h", name, rdata, e);
            end
        end
    endtask

    function automatic vec_t mk(bit rd, bit wr, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] sd, bit es, logic [31:0] er);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd;
        v.sdata = sd; v.exp_sram = es; v.exp_rdata = er;
        return v;
    endfunction

    // One pipeline access; the bench plays the SRAM controller with latency lat
    task automatic run_op(input vec_t v, input int lat, input string tag);
        bit is_rd;
        bit done;
        is_rd = v.rd && !v.wr;
        @(negedge clk);
        MEM_R_EN   = v.rd;
        MEM_W_EN   = v.wr;
        address    = v.addr;
        wdata      = v.wd;
        sram_ready = 1'b1;
        if (is_rd) exp_q.push_back(v.exp_rdata);
        #1;
        chk1({tag, " no_dual_en"}, sram_rd_en & sram_wr_en, 1'b0);
        if (!v.exp_sram) begin
            chk1({tag, " hit_ready"}, ready, 1'b1);
            chk1({tag, " hit_rd_en"}, sram_rd_en, 1'b0);
            chk1({tag, " hit_wr_en"}, sram_wr_en, 1'b0);
            if (is_rd) sb_pop({tag, " hit_rdata"});
        end else begin
            chk1({tag, " req_ready"}, ready, 1'b0);
            chk1({tag, " req_rd_en"}, sram_rd_en, is_rd);
            chk1({tag, " req_wr_en"}, sram_wr_en, v.wr);
            chk32({tag, " sram_addr"}, sram_address, v.addr);
            if (v.wr) chk32({tag, " sram_wdata"}, sram_wdata, v.wd);
            sram_ready = 1'b0;
            done = 1'b0;
            for (int cyc = 0; cyc < lat + 8 && !done; cyc++) begin
                @(negedge clk);
                if (cyc + 1 >= lat) begin
                    sram_ready = 1'b1;
                    sram_rdata = v.sdata;
                end
                #1;
                chk1({tag, " held_rd_en"}, sram_rd_en, is_rd);
                chk1({tag, " held_wr_en"}, sram_wr_en, v.wr);
                chk1({tag, " ready_eq_sram_ready"}, ready, sram_ready);
                if (ready) begin
                    done = 1'b1;
                    if (is_rd) sb_pop({tag, " miss_rdata"});
                end
            end
            if (!done) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s timeout: got ready=0 expected ready=1 within %0d cycles", tag, lat + 8);
            end
        end
        @(negedge clk);
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        sram_ready = 1'b1;
        #1;
        chk1({tag, " idle_ready"}, ready, 1'b1);
        chk1({tag, " idle_rd_en"}, sram_rd_en, 1'b0);
        chk1({tag, " idle_wr_en"}, sram_wr_en, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        address    = 32'h0;
        wdata      = 32'h0;
        sram_rdata = 32'h0;
        sram_ready = 1'b1;

        //              rd wr addr          wdata         sram data     sram exp rdata
        vecs.push_back(mk(1, 0, 32'h400,   32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 32'h400,   32'h0,        32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 32'h404,   32'h12345678, 32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 0, 32'h404,   32'h0,        32'h12345678, 1, 32'h12345678));
        vecs.push_back(mk(1, 0, 32'h400,   32'h0,        32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 32'h500,   32'h0,        32'h55550500, 1, 32'h55550500));
        vecs.push_back(mk(1, 0, 32'h400,   32'h0,        32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 32'h600,   32'h0,        32'h66660600, 1, 32'h66660600));
        vecs.push_back(mk(1, 0, 32'h400,   32'h0,        32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 32'h600,   32'h0,        32'h0,        0, 32'h66660600));
        vecs.push_back(mk(1, 0, 32'h500,   32'h0,        32'h55550500, 1, 32'h55550500));
        vecs.push_back(mk(0, 1, 32'h500,   32'hA5A5A5A5, 32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 0, 32'h500,   32'h0,        32'h0,        0, 32'hA5A5A5A5));
        vecs.push_back(mk(1, 0, 32'h600,   32'h0,        32'h0,        0, 32'h66660600));
        vecs.push_back(mk(1, 1, 32'h408,   32'h0000CAFE, 32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 0, 32'h408,   32'h0,        32'h0000CAFE, 1, 32'h0000CAFE));
        vecs.push_back(mk(0, 1, 32'h600,   32'h77777777, 32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 0, 32'h600,   32'h0,        32'h0,        0, 32'h77777777));
        vecs.push_back(mk(1, 0, 32'h4FC,   32'h0,        32'h3F3F3F3F, 1, 32'h3F3F3F3F));
        vecs.push_back(mk(1, 0, 32'h4FE,   32'h0,        32'h0,        0, 32'h3F3F3F3F));
        vecs.push_back(mk(1, 0, 32'h803FC, 32'h0,        32'h80808080, 1, 32'h80808080));
        vecs.push_back(mk(1, 0, 32'h4FC,   32'h0,        32'h0,        0, 32'h3F3F3F3F));
        vecs.push_back(mk(1, 0, 32'h803FC, 32'h0,        32'h0,        0, 32'h80808080));
        vecs.push_back(mk(1, 0, 32'h404,   32'h0,        32'h0,        0, 32'h12345678));

        // Reset state
        #12;
        chk1("rst_ready", ready, 1'b1);
        chk1("rst_rd_en", sram_rd_en, 1'b0);
        chk1("rst_wr_en", sram_wr_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i], (i % 3) + 1, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a read miss
        @(negedge clk);
        MEM_R_EN   = 1'b1;
        address    = 32'h400;
        sram_ready = 1'b1;
        #1;
        chk1("mid_rst start rd_en", sram_rd_en, 1'b1);
        sram_ready = 1'b0;
        @(negedge clk);
        #1;
        chk1("mid_rst in_miss rd_en", sram_rd_en, 1'b1);
        chk1("mid_rst in_miss ready", ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk1("mid_rst async rd_en", sram_rd_en, 1'b0);
        chk1("mid_rst async wr_en", sram_wr_en, 1'b0);
        MEM_R_EN = 1'b0;
        #1;
        chk1("mid_rst no_req ready", ready, 1'b1);
        @(negedge clk);
        rst        = 1'b0;
        sram_ready = 1'b1;

        // All lines invalid after reset: formerly cached addresses miss
        run_op(mk(1, 0, 32'h400, 32'h0, 32'h11110400, 1, 32'h11110400), 2, "post_rst 0x400");
        run_op(mk(1, 0, 32'h500, 32'h0, 32'h22220500, 1, 32'h22220500), 1, "post_rst 0x500");
        run_op(mk(1, 0, 32'h400, 32'h0, 32'h0,        0, 32'h11110400), 1, "post_rst 0x400 hit");

        // Reset in the middle of a write
        @(negedge clk);
        MEM_W_EN   = 1'b1;
        address    = 32'h500;
        wdata      = 32'hBBBBBBBB;
        sram_ready = 1'b0;
        #1;
        chk1("mid_rst_wr wr_en", sram_wr_en, 1'b1);
        rst = 1'b1;
        #1;
        chk1("mid_rst_wr async wr_en", sram_wr_en, 1'b0);
        MEM_W_EN = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
        sram_ready = 1'b1;
        run_op(mk(1, 0, 32'h500, 32'h0, 32'h33330500, 1, 32'h33330500), 3, "post_rst_wr 0x500");

        chk32("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
